mem_port_ctrl: RTL and testbench

// Load/store access controller between the multicycle datapath and the word-addressed data memory.

---
 rtl/mem_port_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// Load/store port between the multicycle datapath and word-addressed data memory.
// Handles byte/half/word loads with extension and byte/half stores via read-modify-write.
//
// state | meaning
// IDLE  | waiting for req; latches the request and checks alignment/bounds
// READ  | mem_re=1; load result or RMW merge source captured at the closing edge
// WRITE | mem_we=1 (gated by rst_n); writes the full or merged word
// RESP  | done=1 for one cycle with fault flags
module mem_port_ctrl #(
    parameter int MEM_WORDS  = 1024,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        oob,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

    state_t      state;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic [31:0] line_q;
    logic        we_q;

    logic        in_mis;
    logic        in_oob;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Bit position of the addressed byte (half=0) or half (half=1) within the word.
    function automatic logic [4:0] lane_shift(input logic [1:0] off, input logic half);
        logic [4:0] sh;
        if (half) sh = BIG_ENDIAN ? {~off[1], 4'b0000} : {off[1], 4'b0000};
        else      sh = BIG_ENDIAN ? {~off, 3'b000} : {off, 3'b000};
        return sh;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                            input logic [1:0] sz, input logic sgn);
        logic [31:0] s;
        logic [31:0] r;
        s = word >> lane_shift(off, sz[0]);
        if (sz[1])       r = word;
        else if (sz[0])  r = {(sgn ? {16{s[15]}} : 16'h0000), s[15:0]};
        else             r = {(sgn ? {24{s[7]}} : 24'h000000), s[7:0]};
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [15:0] d,
                                          input logic [1:0] off, input logic [1:0] sz);
        logic [4:0]  sh;
        logic [31:0] mask;
        logic [31:0] ins;
        sh = lane_shift(off, sz[0]);
        if (sz[0]) begin
            mask = 32'h0000FFFF << sh;
            ins  = {16'h0000, d} << sh;
        end else begin
            mask = 32'h000000FF << sh;
            ins  = {24'h000000, d[7:0]} << sh;
        end
        return (word & ~mask) | ins;
    endfunction

    always_comb begin
        in_mis   = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
        in_oob   = addr[31:2] >= MEM_LIMIT;
        load_val = extract(mem_rdata, off_q, size_q, sign_q);
        merged   = merge(mem_rdata, wdata_q, off_q, size_q);
    end

    // Reset gates the write strobe combinationally so a reset cycle never commits a word.
    assign mem_we    = we_q & rst_n;
    assign mem_wdata = line_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            oob        <= 1'b0;
            rdata      <= 32'h0;
            mem_addr   <= 32'h0;
            mem_re     <= 1'b0;
            we_q       <= 1'b0;
            line_q     <= 32'h0;
            wr_q       <= 1'b0;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            off_q      <= 2'b00;
            wdata_q    <= 16'h0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            oob        <= 1'b0;
            mem_re     <= 1'b0;
            we_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        wr_q     <= wr;
                        size_q   <= size;
                        sign_q   <= sign_ext;
                        off_q    <= addr[1:0];
                        wdata_q  <= wdata[15:0];
                        mem_addr <= {2'b00, addr[31:2]};
                        line_q   <= wdata;
                        busy     <= 1'b1;
                        if (in_mis || in_oob) begin
                            state      <= RESP;
                            done       <= 1'b1;
                            misaligned <= in_mis;
                            oob        <= in_oob && !in_mis;
                        end else if (!wr || !size[1]) begin
                            state  <= READ;
                            mem_re <= 1'b1;
                        end else begin
                            state <= WRITE;
                            we_q  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    line_q <= wr_q ? merged : mem_rdata;
                    if (wr_q) begin
                        state <= WRITE;
                        we_q  <= 1'b1;
                    end else begin
                        state <= RESP;
                        rdata <= load_val;
                        done  <= 1'b1;
                    end
                end
                WRITE: begin
                    state <= RESP;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural word memory.
module tb_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        oob;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int n_tests = 0;
    int n_fail  = 0;

    mem_port_ctrl #(.MEM_WORDS(1024), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .misaligned(misaligned), .oob(oob), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one request for edge k; leaves the bench #1 into cycle k+1.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; wr = w; size = sz; sign_ext = sg; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    // Full access: returns latency in cycles after accept (99 on timeout) and strobe history.
    task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic saw_re, output logic saw_we,
                          output logic mis, output logic oo);
        lat = 99; saw_re = 1'b0; saw_we = 1'b0; mis = 1'b0; oo = 1'b0;
        issue(w, sz, sg, a, d);
        for (int i = 1; i <= 6; i++) begin
            saw_re |= mem_re;
            saw_we |= mem_we;
            if (done) begin
                lat = i; mis = misaligned; oo = oob;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    int   lat;
    logic sre, swe, mis, oo;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4]    = 32'hDEADBEEF;
        mem[1]    = 32'h12345678;
        mem[1023] = 32'hA5A5A5A5;
        rst_n = 1'b0; req = 1'b1; wr = 1'b1; size = 2'b10; sign_ext = 1'b0;
        addr = 32'h10; wdata = 32'hFFFFFFFF;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_re", {31'b0, mem_re}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_maddr", mem_addr, 32'h0);
        @(negedge clk);
        req = 1'b0; rst_n = 1'b1;

        // LW 0x10 with cycle-exact strobe checks
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw_re_k1", {31'b0, mem_re}, 32'd1);
        check("lw_maddr_k1", mem_addr, 32'd4);
        check("lw_busy_k1", {31'b0, busy}, 32'd1);
        check("lw_done_k1", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        check("lw_done_k2", {31'b0, done}, 32'd1);
        check("lw_busy_k2", {31'b0, busy}, 32'd1);
        check("lw_rdata", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("lw_idle_busy", {31'b0, busy}, 32'd0);
        check("lw_idle_done", {31'b0, done}, 32'd0);

        access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, sre, swe, mis, oo);
        check("lb_lat", lat, 2);
        check("lb_rdata", rdata, 32'hFFFFFFAD);
        access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, sre, swe, mis, oo);
        check("lbu_rdata", rdata, 32'h000000AD);
        access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, sre, swe, mis, oo);
        check("lh_rdata", rdata, 32'hFFFFBEEF);
        access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, sre, swe, mis, oo);
        check("lbu0_rdata", rdata, 32'h000000DE);

        // SB 0x13 via read-modify-write
        issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h55);
        check("sb_re_k1", {31'b0, mem_re}, 32'd1);
        check("sb_we_k1", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        check("sb_we_k2", {31'b0, mem_we}, 32'd1);
        check("sb_wdata_k2", mem_wdata, 32'hDEADBE55);
        check("sb_maddr_k2", mem_addr, 32'd4);
        check("sb_done_k2", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        check("sb_done_k3", {31'b0, done}, 32'd1);
        check("sb_we_k3", {31'b0, mem_we}, 32'd0);
        check("sb_mem4", mem[4], 32'hDEADBE55);
        @(posedge clk); #1;

        access(1'b1, 2'b10, 1'b0, 32'h4, 32'hCAFEF00D, lat, sre, swe, mis, oo);
        check("sw_lat", lat, 2);
        check("sw_re", {31'b0, sre}, 32'd0);
        check("sw_mem1", mem[1], 32'hCAFEF00D);

        // Faults
        access(1'b1, 2'b10, 1'b0, 32'h6, 32'h11111111, lat, sre, swe, mis, oo);
        check("mis_lat", lat, 1);
        check("mis_flag", {31'b0, mis}, 32'd1);
        check("mis_oob", {31'b0, oo}, 32'd0);
        check("mis_strobes", {30'b0, sre, swe}, 32'd0);
        check("mis_mem1", mem[1], 32'hCAFEF00D);
        access(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, sre, swe, mis, oo);
        check("oob_lat", lat, 1);
        check("oob_flag", {31'b0, oo}, 32'd1);
        check("oob_mis", {31'b0, mis}, 32'd0);
        check("oob_strobes", {30'b0, sre, swe}, 32'd0);
        check("oob_rdata_held", rdata, 32'h000000DE);
        access(1'b0, 2'b01, 1'b0, 32'h1001, 32'h0, lat, sre, swe, mis, oo);
        check("prio_mis", {31'b0, mis}, 32'd1);
        check("prio_oob", {31'b0, oo}, 32'd0);
        access(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, lat, sre, swe, mis, oo);
        check("last_word_oob", {31'b0, oo}, 32'd0);
        check("last_word_rdata", rdata, 32'hA5A5A5A5);
        access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, sre, swe, mis, oo);
        check("size3_rdata", rdata, 32'hDEADBE55);

        // SH 0x10 aborted by reset in the WRITE cycle
        issue(1'b1, 2'b01, 1'b0, 32'h10, 32'h1234);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstw_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        check("rstw_done", {31'b0, done}, 32'd0);
        check("rstw_busy", {31'b0, busy}, 32'd0);
        check("rstw_mem4", mem[4], 32'hDEADBE55);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstw_done2", {31'b0, done}, 32'd0);
        access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, sre, swe, mis, oo);
        check("post_rst_lat", lat, 2);
        check("post_rst_rdata", rdata, 32'hDEADBE55);

        access(1'b1, 2'b01, 1'b0, 32'h10, 32'hCAFE, lat, sre, swe, mis, oo);
        check("sh_lat", lat, 3);
        check("sh_mem4", mem[4], 32'hCAFEBE55);
        access(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, sre, swe, mis, oo);
        check("lhu_rdata", rdata, 32'h0000CAFE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
